// File: rtl/acondicionador_botones.sv
// Purpose : synchronise and debounce the two raw push-buttons (BTN0 -> botonclk,
//           BTN2 -> botonxs) into clean levels plus a one-cycle press pulse each.
// Latency : a new raw level reaches the outputs DEBOUNCE_CYCLES+3 clk edges after
//           it is first sampled; press and release take the same time.
// Backpr. : none; the outputs are free-running levels/pulses with no handshake.
// Ports   : clk, botonreset (async, active-high), botonclk_raw, botonxs_raw in;
//           botonclk_limpio, botonxs_limpio, pulso_clk, pulso_xs out.
//           All outputs are registered, so the clean levels can safely clock
//           the downstream multiplier.

// One debounce channel: 2-flop synchroniser feeding a 4-state filter FSM.
module acondicionador_canal #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic botonreset,
  input  logic boton_raw,
  output logic limpio,
  output logic pulso
);

  typedef enum logic [1:0] {
    REPOSO      = 2'd0,
    FILT_SUBIDA = 2'd1,
    PULSADO     = 2'd2,
    FILT_BAJADA = 2'd3
  } estado_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1_q;
  logic                 s2_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  estado_t              estado_q;
  logic                 limpio_q;
  logic                 pulso_q;

  always_ff @(posedge clk or posedge botonreset) begin
    if (botonreset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      estado_q <= REPOSO;
      limpio_q <= 1'b0;
      pulso_q  <= 1'b0;
    end else begin
      s1_q    <= boton_raw;
      s2_q    <= s1_q;
      // The pulse lives for exactly the edge that enters PULSADO.
      pulso_q <= 1'b0;
      case (estado_q)
        REPOSO: begin
          cnt_q <= '0;
          if (s2_q) estado_q <= FILT_SUBIDA;
        end
        FILT_SUBIDA: begin
          if (!s2_q) begin
            // Bounce or glitch: drop back without touching the outputs.
            estado_q <= REPOSO;
            cnt_q    <= '0;
          end else if (cnt_q == CNT_MAX) begin
            estado_q <= PULSADO;
            cnt_q    <= '0;
            limpio_q <= 1'b1;
            pulso_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        PULSADO: begin
          cnt_q <= '0;
          if (!s2_q) estado_q <= FILT_BAJADA;
        end
        FILT_BAJADA: begin
          if (s2_q) begin
            estado_q <= PULSADO;
            cnt_q    <= '0;
          end else if (cnt_q == CNT_MAX) begin
            // Release: level falls, no pulse.
            estado_q <= REPOSO;
            cnt_q    <= '0;
            limpio_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          estado_q <= REPOSO;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign limpio = limpio_q;
  assign pulso  = pulso_q;

endmodule

// Top level: two identical, independent channels.
module acondicionador_botones #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic botonreset,
  input  logic botonclk_raw,
  input  logic botonxs_raw,
  output logic botonclk_limpio,
  output logic botonxs_limpio,
  output logic pulso_clk,
  output logic pulso_xs
);

  acondicionador_canal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_canal_clk (
    .clk       (clk),
    .botonreset(botonreset),
    .boton_raw (botonclk_raw),
    .limpio    (botonclk_limpio),
    .pulso     (pulso_clk)
  );

  acondicionador_canal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_canal_xs (
    .clk       (clk),
    .botonreset(botonreset),
    .boton_raw (botonxs_raw),
    .limpio    (botonxs_limpio),
    .pulso     (pulso_xs)
  );

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones with DEBOUNCE_CYCLES=4: directed test-plan
// sequences followed by random bouncing inputs, every cycle compared against
// a run-length reference model (a level flips after D+1 consecutive differing
// samples, seen through a two-sample synchroniser delay).
module tb_acondicionador_botones;

  localparam int D = 4;

  logic clk = 1'b0;
  logic botonreset = 1'b1;
  logic botonclk_raw = 1'b0;
  logic botonxs_raw = 1'b0;
  logic botonclk_limpio, botonxs_limpio, pulso_clk, pulso_xs;

  acondicionador_botones #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (3)
  ) dut (
    .clk            (clk),
    .botonreset     (botonreset),
    .botonclk_raw   (botonclk_raw),
    .botonxs_raw    (botonxs_raw),
    .botonclk_limpio(botonclk_limpio),
    .botonxs_limpio (botonxs_limpio),
    .pulso_clk      (pulso_clk),
    .pulso_xs       (pulso_xs)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state, index 0 = botonclk, 1 = botonxs.
  bit m_hist [2][2];   // [ch][0] = raw one edge ago, [ch][1] = two edges ago
  int m_run  [2];      // consecutive samples differing from the accepted level
  bit m_lvl  [2];
  bit m_pul  [2];

  // Observation bookkeeping for the directed sequences.
  int e_rel;
  int p_cnt  [2];
  int p_edge [2];
  int f_edge [2];
  bit lvl_seen [2];
  bit prev_l [2];

  task automatic check_val(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_hist[c][0] = 1'b0;
      m_hist[c][1] = 1'b0;
      m_run[c]     = 0;
      m_lvl[c]     = 1'b0;
      m_pul[c]     = 1'b0;
    end
  endtask

  task automatic model_edge(input bit r0, input bit r1);
    bit raw [2];
    bit s;
    raw[0] = r0;
    raw[1] = r1;
    for (int c = 0; c < 2; c++) begin
      s        = m_hist[c][1];
      m_pul[c] = 1'b0;
      if (s != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == D + 1) begin
          m_lvl[c] = s;
          m_pul[c] = s;   // only rising acceptance pulses
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_hist[c][1] = m_hist[c][0];
      m_hist[c][0] = raw[c];
    end
  endtask

  task automatic mark();
    e_rel = 0;
    for (int c = 0; c < 2; c++) begin
      p_cnt[c]    = 0;
      p_edge[c]   = -1;
      f_edge[c]   = -1;
      lvl_seen[c] = 1'b0;
    end
  endtask

  // Entered and left at a falling edge: drive raw, take one rising edge, check.
  task automatic step(input bit c, input bit x);
    bit o_l [2];
    bit o_p [2];
    botonclk_raw = c;
    botonxs_raw  = x;
    @(posedge clk);
    model_edge(c, x);
    #1;
    check_val("lvl_clk", int'(botonclk_limpio), int'(m_lvl[0]));
    check_val("lvl_xs",  int'(botonxs_limpio),  int'(m_lvl[1]));
    check_val("pul_clk", int'(pulso_clk),       int'(m_pul[0]));
    check_val("pul_xs",  int'(pulso_xs),        int'(m_pul[1]));
    e_rel++;
    o_l[0] = botonclk_limpio;
    o_l[1] = botonxs_limpio;
    o_p[0] = pulso_clk;
    o_p[1] = pulso_xs;
    for (int ch = 0; ch < 2; ch++) begin
      if (o_p[ch]) begin
        if (p_cnt[ch] == 0) p_edge[ch] = e_rel;
        p_cnt[ch]++;
      end
      if (o_l[ch]) lvl_seen[ch] = 1'b1;
      if (!o_l[ch] && prev_l[ch] && f_edge[ch] < 0) f_edge[ch] = e_rel;
      prev_l[ch] = o_l[ch];
    end
    @(negedge clk);
  endtask

  // Entered at a falling edge; asserts reset mid-cycle, checks the outputs
  // clear before any clock edge, releases on a later falling edge.
  task automatic do_reset(input int hold);
    #5 botonreset = 1'b1;
    #1;
    check_val("rst_lvl_clk", int'(botonclk_limpio), 0);
    check_val("rst_lvl_xs",  int'(botonxs_limpio),  0);
    check_val("rst_pul_clk", int'(pulso_clk),       0);
    check_val("rst_pul_xs",  int'(pulso_xs),        0);
    model_reset();
    prev_l[0] = 1'b0;
    prev_l[1] = 1'b0;
    repeat (hold) @(negedge clk);
    botonreset = 1'b0;
  endtask

  initial begin
    bit pat [10];
    bit rc, rx;
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    model_reset();
    prev_l[0] = 1'b0;
    prev_l[1] = 1'b0;
    mark();

    // Reset state while reset is held from time zero.
    #5;
    check_val("init_lvl_clk", int'(botonclk_limpio), 0);
    check_val("init_lvl_xs",  int'(botonxs_limpio),  0);
    check_val("init_pul_clk", int'(pulso_clk),       0);
    check_val("init_pul_xs",  int'(pulso_xs),        0);
    @(negedge clk);
    botonreset = 1'b0;

    // 1: both buttons held, then reset mid-cycle with raw inputs still high.
    repeat (12) step(1'b1, 1'b1);
    check_val("t1_lvl_up", int'({botonclk_limpio, botonxs_limpio}), 3);
    do_reset(2);
    repeat (12) step(1'b0, 1'b0);

    // 2: clean press and release on botonclk.
    mark();
    repeat (10) step(1'b1, 1'b0);
    check_val("t2_pulse_edge", p_edge[0], 7);
    check_val("t2_pulse_cnt",  p_cnt[0], 1);
    check_val("t2_level_held", int'(botonclk_limpio), 1);
    mark();
    repeat (10) step(1'b0, 1'b0);
    check_val("t2_fall_edge",       f_edge[0], 7);
    check_val("t2_release_pulses",  p_cnt[0], 0);

    // 3: bounce 1,1,1,1,0 then a solid run; pulse only after 5 clean ones.
    mark();
    foreach (pat[i]) step(pat[i], 1'b0);
    repeat (4) step(1'b1, 1'b0);
    check_val("t3_pulse_cnt",  p_cnt[0], 1);
    check_val("t3_pulse_edge", p_edge[0], 12);
    repeat (10) step(1'b0, 1'b0);

    // 4: botonxs high for only 4 edges is rejected.
    mark();
    repeat (4) step(1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0);
    check_val("t4_pulse_cnt", p_cnt[1], 0);
    check_val("t4_lvl_seen",  int'(lvl_seen[1]), 0);

    // 5: simultaneous presses accept on the same edge.
    mark();
    repeat (10) step(1'b1, 1'b1);
    check_val("t5_edge_clk", p_edge[0], 7);
    check_val("t5_edge_xs",  p_edge[1], 7);
    repeat (10) step(1'b0, 1'b0);

    // 6: reset during the rising filter, button still held afterwards.
    mark();
    repeat (5) step(1'b1, 1'b0);
    check_val("t6_no_early_pulse", p_cnt[0], 0);
    do_reset(1);
    mark();
    repeat (10) step(1'b1, 1'b0);
    check_val("t6_fresh_edge", p_edge[0], 7);
    check_val("t6_fresh_cnt",  p_cnt[0], 1);
    repeat (10) step(1'b0, 1'b0);

    // Random bouncing buttons with occasional resets.
    rc = 1'b0;
    rx = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) rc = ~rc;
      if ($urandom_range(0, 7) == 0) rx = ~rx;
      step(rc, rx);
      if ($urandom_range(0, 499) == 0) do_reset(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
